// File: rtl/gon_gather.sv
// rtl/gon_gather.sv - round-robin gather of a PE array's result words into one output register
// Optional word counter output enabled by defining GON_GATHER_COUNT_EN.
module gon_gather #(
  parameter int DATA_WIDTH    = 64,
  parameter int ROW_TAG_WIDTH = 4,
  parameter int COL_TAG_WIDTH = 4,
  parameter int NUM_OF_ROWS   = 12,
  parameter int NUM_OF_COLS   = 14
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable_in,
  input  logic [DATA_WIDTH-1:0]    data_in [0:NUM_OF_ROWS-1][0:NUM_OF_COLS-1],
  input  logic [0:NUM_OF_COLS-1]   valid_in [0:NUM_OF_ROWS-1],
  output logic [0:NUM_OF_COLS-1]   ready_out [0:NUM_OF_ROWS-1],
  output logic [DATA_WIDTH-1:0]    data_out,
  output logic [ROW_TAG_WIDTH-1:0] row_tag_out,
  output logic [COL_TAG_WIDTH-1:0] col_tag_out,
  output logic                     valid_out,
  input  logic                     ready_in,
  output logic                     busy_out
`ifdef GON_GATHER_COUNT_EN
  ,
  output logic [31:0]              word_count
`endif
);

  localparam int K     = NUM_OF_ROWS * NUM_OF_COLS;
  localparam int PTR_W = (K > 1) ? $clog2(K) : 1;

  typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN} state_t;

  state_t                   state, state_next;
  logic [PTR_W-1:0]         rr_ptr;
  logic [K-1:0]             req, mask, hi;
  logic                     drain, grant;
  logic [PTR_W-1:0]         gnt_k;
  logic [DATA_WIDTH-1:0]    gnt_data;
  logic [ROW_TAG_WIDTH-1:0] gnt_row;
  logic [COL_TAG_WIDTH-1:0] gnt_col;

  function automatic logic [PTR_W-1:0] first_set(input logic [K-1:0] v);
    first_set = '0;
    for (int i = K - 1; i >= 0; i--)
      if (v[i]) first_set = PTR_W'(i);
  endfunction

  always_comb begin
    req = '0;
    for (int r = 0; r < NUM_OF_ROWS; r++)
      for (int c = 0; c < NUM_OF_COLS; c++)
        req[r*NUM_OF_COLS+c] = valid_in[r][c];
  end

  // Requesters at or above rr_ptr win first; otherwise wrap to the lowest index.
  always_comb begin
    mask = '0;
    for (int i = 0; i < K; i++)
      mask[i] = (i >= int'(rr_ptr));
  end

  assign hi    = req & mask;
  assign gnt_k = (|hi) ? first_set(hi) : first_set(req);
  assign drain = valid_out & ready_in;
  assign grant = reset & enable_in & (state == ACTIVE) & (~valid_out | ready_in) & (|req);

  always_comb begin
    gnt_data = '0;
    gnt_row  = '0;
    gnt_col  = '0;
    for (int r = 0; r < NUM_OF_ROWS; r++) begin
      ready_out[r] = '0;
      for (int c = 0; c < NUM_OF_COLS; c++) begin
        if (gnt_k == PTR_W'(r*NUM_OF_COLS+c)) begin
          ready_out[r][c] = grant;
          gnt_data        = data_in[r][c];
          gnt_row         = ROW_TAG_WIDTH'(r);
          gnt_col         = COL_TAG_WIDTH'(c);
        end
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (enable_in) state_next = ACTIVE;
      ACTIVE:  if (!enable_in) state_next = valid_out ? DRAIN : IDLE;
      DRAIN: begin
        if (enable_in) state_next = ACTIVE;
        else if (!valid_out || ready_in) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      valid_out   <= 1'b0;
      data_out    <= '0;
      row_tag_out <= '0;
      col_tag_out <= '0;
    end else begin
      state <= state_next;
      if (grant) begin
        rr_ptr      <= (gnt_k == PTR_W'(K - 1)) ? '0 : gnt_k + PTR_W'(1);
        valid_out   <= 1'b1;
        data_out    <= gnt_data;
        row_tag_out <= gnt_row;
        col_tag_out <= gnt_col;
      end else if (drain) begin
        valid_out <= 1'b0;
      end
    end
  end

  assign busy_out = (state != IDLE);

`ifdef GON_GATHER_COUNT_EN
  always_ff @(posedge clk) begin
    if (!reset)
      word_count <= '0;
    else if (state != IDLE && state_next == IDLE)
      word_count <= '0;
    else if (drain)
      word_count <= word_count + 32'd1;
  end
`endif

endmodule

// File: tb/tb_gon_gather.sv
// tb/tb_gon_gather.sv - directed scoreboard bench for gon_gather
module tb_gon_gather;

  localparam int R = 12;
  localparam int C = 14;

  typedef struct {
    logic [3:0]  r;
    logic [3:0]  c;
    logic [63:0] d;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable_in;
  logic [63:0] data_in [0:R-1][0:C-1];
  logic [0:C-1] valid_in [0:R-1];
  logic [0:C-1] ready_out [0:R-1];
  logic [63:0] data_out;
  logic [3:0]  row_tag_out;
  logic [3:0]  col_tag_out;
  logic        valid_out;
  logic        ready_in;
  logic        busy_out;
`ifdef GON_GATHER_COUNT_EN
  logic [31:0] word_count;
`endif

  int   compared   = 0;
  int   mismatched = 0;
  exp_t exp_q[$];

  gon_gather dut (
    .clk(clk), .reset(reset), .enable_in(enable_in),
    .data_in(data_in), .valid_in(valid_in), .ready_out(ready_out),
    .data_out(data_out), .row_tag_out(row_tag_out), .col_tag_out(col_tag_out),
    .valid_out(valid_out), .ready_in(ready_in), .busy_out(busy_out)
`ifdef GON_GATHER_COUNT_EN
    , .word_count(word_count)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] pat(input int r, input int c);
    if (r == 3 && c == 5) return 64'hA5;
    return {32'hC0DE_0000 | 32'(r), 32'h5A00_0000 | 32'(c)};
  endfunction

  function automatic int ones();
    int n = 0;
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++)
        n += int'(ready_out[r][c]);
    return n;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push(input int r, input int c);
    exp_t e;
    e.r = 4'(r);
    e.c = 4'(c);
    e.d = pat(r, c);
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (reset && valid_out && ready_in) begin
      exp_t e;
      check("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("sb_data", data_out, e.d);
        check("sb_row", 64'(row_tag_out), 64'(e.r));
        check("sb_col", 64'(col_tag_out), 64'(e.c));
      end
    end
  end

  initial begin
    int seq_r[6] = '{0, 0, 11, 0, 0, 11};
    int seq_c[6] = '{0, 13, 13, 0, 13, 13};

    for (int r = 0; r < R; r++) begin
      valid_in[r] = '1;
      for (int c = 0; c < C; c++) data_in[r][c] = pat(r, c);
    end
    reset = 1'b0; enable_in = 1'b1; ready_in = 1'b0;

    // reset with every PE requesting
    tick(); tick();
    check("rst_valid", 64'(valid_out), 64'd0);
    check("rst_data", data_out, 64'd0);
    check("rst_row", 64'(row_tag_out), 64'd0);
    check("rst_col", 64'(col_tag_out), 64'd0);
    check("rst_busy", 64'(busy_out), 64'd0);
    check("rst_ready", 64'(ones()), 64'd0);

    for (int r = 0; r < R; r++) valid_in[r] = '0;
    enable_in = 1'b0; reset = 1'b1;
    tick();

    // single requester PE(3,5)
    valid_in[3][5] = 1'b1; enable_in = 1'b1; ready_in = 1'b1;
    #1 check("idle_nogrant", 64'(ones()), 64'd0);
    tick();
    check("a5_ready", 64'(ready_out[3][5]), 64'd1);
    check("a5_busy", 64'(busy_out), 64'd1);
    push(3, 5);
    tick();
    valid_in[3][5] = 1'b0;
    #1;
    check("a5_data", data_out, 64'hA5);
    check("a5_row", 64'(row_tag_out), 64'd3);
    check("a5_col", 64'(col_tag_out), 64'd5);
    check("a5_valid", 64'(valid_out), 64'd1);
    tick();
    check("a5_cleared", 64'(valid_out), 64'd0);

    // round-robin over three corners, starting from a fresh pointer
    reset = 1'b0;
    tick();
    reset = 1'b1;
    valid_in[0][0] = 1'b1; valid_in[0][13] = 1'b1; valid_in[11][13] = 1'b1;
    tick();
    for (int i = 0; i < 6; i++) begin
      #1;
      check("rr_grant", 64'(ready_out[seq_r[i]][seq_c[i]]), 64'd1);
      check("rr_onehot", 64'(ones()), 64'd1);
      if (i > 0) check("rr_nobubble", 64'(valid_out), 64'd1);
      push(seq_r[i], seq_c[i]);
      tick();
    end
    valid_in[0][0] = 1'b0; valid_in[0][13] = 1'b0; valid_in[11][13] = 1'b0;
    tick();
    check("rr_done", 64'(valid_out), 64'd0);

    // backpressure on PE(2,2)
    ready_in = 1'b0;
    valid_in[2][2] = 1'b1;
    #1 check("bp_first", 64'(ready_out[2][2]), 64'd1);
    push(2, 2);
    tick();
    for (int i = 0; i < 4; i++) begin
      #1;
      check("bp_nogrant", 64'(ones()), 64'd0);
      check("bp_hold_valid", 64'(valid_out), 64'd1);
      check("bp_hold_data", data_out, pat(2, 2));
      tick();
    end
    ready_in = 1'b1;
    #1 check("bp_regrant", 64'(ready_out[2][2]), 64'd1);
    push(2, 2);
    tick();
    valid_in[2][2] = 1'b0;
    tick();
    check("bp_done", 64'(valid_out), 64'd0);

    // enable drops while a word is stalled
    ready_in = 1'b0;
    valid_in[5][7] = 1'b1;
    push(5, 7);
    tick();
    valid_in[5][7] = 1'b0;
    enable_in = 1'b0;
    tick();
    valid_in[5][7] = 1'b1;
    #1;
    check("dr_busy", 64'(busy_out), 64'd1);
    check("dr_valid", 64'(valid_out), 64'd1);
    check("dr_nogrant", 64'(ones()), 64'd0);
    tick();
    ready_in = 1'b1;
    #1 check("dr_nogrant2", 64'(ones()), 64'd0);
    tick();
    valid_in[5][7] = 1'b0;
    check("dr_idle_busy", 64'(busy_out), 64'd0);
    check("dr_idle_valid", 64'(valid_out), 64'd0);

`ifdef GON_GATHER_COUNT_EN
    enable_in = 1'b1;
    valid_in[1][1] = 1'b1;
    for (int i = 0; i < 5; i++) push(1, 1);
    tick();
    for (int i = 0; i < 5; i++) tick();
    valid_in[1][1] = 1'b0;
    tick();
    check("cnt_five", 64'(word_count), 64'd5);
    enable_in = 1'b0;
    tick();
    check("cnt_clear", 64'(word_count), 64'd0);
`endif

    // reset while a word is held
    enable_in = 1'b1; ready_in = 1'b0;
    valid_in[4][4] = 1'b1;
    tick();
    tick();
    check("mr_held", 64'(valid_out), 64'd1);
    reset = 1'b0; ready_in = 1'b1;
    #1 check("mr_nogrant", 64'(ones()), 64'd0);
    tick();
    check("mr_valid", 64'(valid_out), 64'd0);
    check("mr_data", data_out, 64'd0);
    check("mr_busy", 64'(busy_out), 64'd0);
    reset = 1'b1; enable_in = 1'b0; valid_in[4][4] = 1'b0;
    tick();

    check("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/gon_gather.md
GON_GATHER -- requirements
Module: gon_gather

Interface
REQ-001 Parameters (name, default, meaning), one per line: SHALL provide DATA_WIDTH, 64, word width.
REQ-002 SHALL provide ROW_TAG_WIDTH, 4, width of row_tag_out.
REQ-003 SHALL provide COL_TAG_WIDTH, 4, width of col_tag_out.
REQ-004 SHALL provide NUM_OF_ROWS, 12, PE rows.
REQ-005 SHALL provide NUM_OF_COLS, 14, PE columns.
REQ-006 Ports (name, direction, width, meaning), one per line: clk, input, 1, the single clock; all state on rising edge.
REQ-007 reset, input, 1, synchronous, active-low reset.
REQ-008 enable_in, input, 1, gathering enabled.
REQ-009 data_in, input, DATA_WIDTH per PE [0:NUM_OF_ROWS-1][0:NUM_OF_COLS-1], PE result words.
REQ-010 valid_in, input, [0:NUM_OF_COLS-1] per row [0:NUM_OF_ROWS-1], PE word pending.
REQ-011 ready_out, output, [0:NUM_OF_COLS-1] per row, one-hot grant; the PE word is consumed this cycle.
REQ-012 data_out, output, DATA_WIDTH, gathered word to global buffer.
REQ-013 row_tag_out, output, ROW_TAG_WIDTH, source row index.
REQ-014 col_tag_out, output, COL_TAG_WIDTH, source column index.
REQ-015 valid_out, output, 1, output register holds a word.
REQ-016 ready_in, input, 1, global buffer accepts the word.
REQ-017 busy_out, output, 1, high whenever state is not IDLE.

Function
REQ-018 SHALL order requesters row-major, index k = r*NUM_OF_COLS + c, for k = 0..R*C-1.
REQ-019 SHALL grant at most one requester per cycle, choosing the first valid k at or after rr_ptr, with wrap-around past R*C-1 to 0.
REQ-020 SHALL raise a grant only when enable_in=1, state is ACTIVE, and the output register is empty or draining this cycle (valid_out & ready_in).
REQ-021 SHALL derive ready_out combinationally from the grant (one-hot, or all zero).
REQ-022 On a grant, SHALL load data_in, row_tag_out=r and col_tag_out=c into the output register and set valid_out on the next edge; latency is 1 cycle.
REQ-023 On a grant to k, SHALL set rr_ptr to k+1, or to 0 when k=R*C-1; with no grant, rr_ptr SHALL hold.
REQ-024 SHALL hold data_out, tags and valid_out stable while valid_out=1 and ready_in=0.
REQ-025 When the word drains (valid_out & ready_in) with no grant that cycle, SHALL clear valid_out on the next edge.
REQ-026 When a drain and a grant occur in the same cycle, SHALL load the new word with valid_out kept at 1, giving one word per cycle sustained.
REQ-027 FSM transitions:
- IDLE to ACTIVE when enable_in=1.
- ACTIVE to DRAIN when enable_in=0 and valid_out=1.
- ACTIVE to IDLE when enable_in=0 and valid_out=0.
- DRAIN to IDLE when the held word drains.
- DRAIN to ACTIVE when enable_in returns to 1.
REQ-028 No grants SHALL be issued in IDLE or DRAIN.
REQ-029 ready_in SHALL be ignored while valid_out=0.

Reset
REQ-030 While reset=0 at a clock edge: state=IDLE, rr_ptr=0, valid_out=0, data_out=0, row_tag_out=0, col_tag_out=0, ready_out all 0, and any counter=0.
REQ-031 Reset mid-transfer SHALL discard the held word; no grant SHALL be issued during the reset cycle.

Configuration
REQ-032 With macro GON_GATHER_COUNT_EN defined:
- SHALL add output word_count (32 bits, unsigned).
- word_count SHALL increment on each drain (valid_out & ready_in) and wrap from 2^32-1 to 0.
- word_count SHALL clear when state enters IDLE.
REQ-033 Without GON_GATHER_COUNT_EN, the port and the counter SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-034 Reset=0 for 2 cycles with all valid_in=1 -> all outputs 0, no ready_out bit high.
REQ-035 enable_in=1, only PE(3,5) valid, data 0xA5, ready_in=1 -> ready_out[3][5] high 1 cycle after ACTIVE; next cycle data_out=0xA5, row_tag_out=3, col_tag_out=5, valid_out=1.
REQ-036 PEs (0,0), (0,13) and (11,13) held valid, ready_in=1 -> grants in order k=0, 13, 167, then 0 again; one word per cycle, no bubbles.
REQ-037 ready_in=0 for 4 cycles with PE(2,2) valid -> exactly one grant; outputs stable for 4 cycles; next grant only in the cycle ready_in=1.
REQ-038 enable_in drops while valid_out=1 and ready_in=0 -> state DRAIN, busy_out=1, no grants; on ready_in=1 the word drains, then IDLE and busy_out=0.
REQ-039 With GON_GATHER_COUNT_EN defined, drain 5 words, then deassert enable_in -> word_count=5, then 0 after IDLE is entered.
